prog_loader: RTL and testbench

//   Host-side sequencer that sits directly upstream of the CPU core. It streams 9-bit

---
 rtl/prog_loader_if.sv | 45 ++++
 rtl/prog_loader.sv | 174 +++++++++++++++++
 tb/tb_prog_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
//   Bundles the host load stream, the instruction-memory write port, the CPU
//   core control/status lines and the loader status outputs used by
//   prog_loader.
//
//   modport slave  : the loader itself
//                    in : load_req, load_len, in_valid, in_data, cpu_done
//                    out: in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset,
//                         cpu_start, busy, run_done, cycle_count, timeout
//   modport master : the host/core side (directions mirrored)
// -----------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9,
  parameter int CYC_W   = 16
);
  logic               load_req;
  logic [ADDR_W:0]    load_len;
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_reset;
  logic               cpu_start;
  logic               cpu_done;
  logic               busy;
  logic               run_done;
  logic [CYC_W-1:0]   cycle_count;
  logic               timeout;

  modport slave (
    input  load_req, load_len, in_valid, in_data, cpu_done,
    output in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, cpu_start,
           busy, run_done, cycle_count, timeout
  );

  modport master (
    output load_req, load_len, in_valid, in_data, cpu_done,
    input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, cpu_start,
           busy, run_done, cycle_count, timeout
  );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Host-side sequencer in front of the CPU core. Streams instruction words
//   into instruction memory while holding the core in reset, pulses the core
//   start, then counts execution cycles until the core reports done.
//
//   Ports
//     clk    : system clock (posedge)
//     reset  : synchronous, active-high
//     bus    : prog_loader_if.slave (host stream, imem write port, core
//              reset/start/done, busy/run_done/cycle_count/timeout status)
//
//   Optional feature
//     LOADER_WATCHDOG_EN : when defined, a run that reaches WDOG_LIMIT cycles
//                          without cpu_done ends in DONE with timeout=1 and the
//                          core put back into reset. When undefined, timeout
//                          stays 0 and RUN waits indefinitely.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int               ADDR_W     = 8,
  parameter int               INSTR_W    = 9,
  parameter int               CYC_W      = 16,
  parameter logic [CYC_W-1:0] WDOG_LIMIT = {CYC_W{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  prog_loader_if.slave    bus
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0]  CNT_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

`ifdef LOADER_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_e;

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // Requests longer than the memory depth are trimmed to the depth.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic               we_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [INSTR_W-1:0] wdata_q;

  logic accept, last_word, wdog_trip, new_load;
  logic in_ready, cpu_reset, cpu_start, busy, run_done;

  assign new_load  = bus.load_req && (bus.load_len != '0);
  assign last_word = ({1'b0, ptr_q} == (len_q - LEN_ONE));
  assign wdog_trip = WDOG_EN && (cnt_q == (WDOG_LIMIT - CNT_ONE));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    cpu_start = 1'b0;
    busy      = 1'b0;
    run_done  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          run_done  = 1'b1;
          // A watchdog-ended run puts the core back into reset; a normal
          // completion leaves it halted.
          cpu_reset = tmo_q;
        end
        if (new_load) begin
          state_d = LOAD;
          len_d   = clamp_len(bus.load_len);
          ptr_d   = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = bus.in_valid;
        if (accept) begin
          ptr_d = ptr_q + PTR_ONE;
          if (last_word) state_d = START;
        end
      end
      START: begin
        cpu_reset = 1'b0;
        cpu_start = 1'b1;
        busy      = 1'b1;
        cnt_d     = '0;
        tmo_d     = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        busy      = 1'b1;
        // The cycle in which done is seen is not counted; done beats the
        // watchdog when both happen together.
        if (bus.cpu_done) begin
          state_d = DONE;
        end else if (wdog_trip) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          cnt_d   = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- control state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---- registered instruction-memory write port (one cycle after accept) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        waddr_q <= ptr_q;
        wdata_q <= bus.in_data;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.imem_we     = we_q;
  assign bus.imem_waddr  = waddr_q;
  assign bus.imem_wdata  = wdata_q;
  assign bus.cpu_reset   = cpu_reset;
  assign bus.cpu_start   = cpu_start;
  assign bus.busy        = busy;
  assign bus.run_done    = run_done;
  assign bus.cycle_count = cnt_q;
  assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;
  localparam int CYC_W   = 16;
`ifdef LOADER_WATCHDOG_EN
  localparam logic [15:0] WDOG = 16'd20;
`else
  localparam logic [15:0] WDOG = 16'hFFFF;
`endif

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CYC_W(CYC_W)) bus ();

  prog_loader #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CYC_W(CYC_W), .WDOG_LIMIT(WDOG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        lr;
    logic [8:0]  len;
    logic        iv;
    logic [8:0]  d;
    logic        dn;
    logic        ir;
    logic        we;
    logic [7:0]  a;
    logic [8:0]  wd;
    logic        crst;
    logic        cst;
    logic        busy;
    logic        rd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lr, input logic [8:0] len, input logic iv,
                       input logic [8:0] d, input logic dn);
    bus.load_req = lr;
    bus.load_len = len;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.cpu_done = dn;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].lr, tbl[i].len, tbl[i].iv, tbl[i].d, tbl[i].dn);
      step();
      chk($sformatf("row%0d.in_ready", i),  32'(bus.in_ready),    32'(tbl[i].ir));
      chk($sformatf("row%0d.imem_we", i),   32'(bus.imem_we),     32'(tbl[i].we));
      chk($sformatf("row%0d.waddr", i),     32'(bus.imem_waddr),  32'(tbl[i].a));
      chk($sformatf("row%0d.wdata", i),     32'(bus.imem_wdata),  32'(tbl[i].wd));
      chk($sformatf("row%0d.cpu_reset", i), 32'(bus.cpu_reset),   32'(tbl[i].crst));
      chk($sformatf("row%0d.cpu_start", i), 32'(bus.cpu_start),   32'(tbl[i].cst));
      chk($sformatf("row%0d.busy", i),      32'(bus.busy),        32'(tbl[i].busy));
      chk($sformatf("row%0d.run_done", i),  32'(bus.run_done),    32'(tbl[i].rd));
      chk($sformatf("row%0d.cycles", i),    32'(bus.cycle_count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d.timeout", i),   32'(bus.timeout),     32'd0);
    end
  endtask

  initial begin
    //          lr   len     iv   d        dn | ir  we  a      wd       crst cst busy rd  cnt
    // From reset: zero length ignored, then T1 (3 words back to back).
    tbl[0]  = '{1'b1, 9'd0,  1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'd0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 9'd3,  1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'd0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 9'd0,  1'b1, 9'h101, 1'b0, 1'b1, 1'b1, 8'd0, 9'h101, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 9'd0,  1'b1, 9'h0A2, 1'b0, 1'b1, 1'b1, 8'd1, 9'h0A2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 9'd0,  1'b1, 9'h1C0, 1'b0, 1'b0, 1'b1, 8'd2, 9'h1C0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 9'd0,  1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 8'd2, 9'h1C0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    // From DONE (cycles=10): T2 gapped load of 2 words, load_req in LOAD ignored,
    // in_valid outside LOAD ignored, done in first RUN cycle -> 0 cycles.
    tbl[6]  = '{1'b1, 9'd2,  1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'd2, 9'h1C0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd10};
    tbl[7]  = '{1'b0, 9'd0,  1'b1, 9'h055, 1'b0, 1'b1, 1'b1, 8'd0, 9'h055, 1'b1, 1'b0, 1'b1, 1'b0, 16'd10};
    tbl[8]  = '{1'b1, 9'd5,  1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'd0, 9'h055, 1'b1, 1'b0, 1'b1, 1'b0, 16'd10};
    tbl[9]  = '{1'b0, 9'd0,  1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 8'd0, 9'h055, 1'b1, 1'b0, 1'b1, 1'b0, 16'd10};
    tbl[10] = '{1'b0, 9'd0,  1'b1, 9'h1AA, 1'b0, 1'b0, 1'b1, 8'd1, 9'h1AA, 1'b0, 1'b1, 1'b1, 1'b0, 16'd10};
    tbl[11] = '{1'b0, 9'd0,  1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0, 8'd1, 9'h1AA, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[12] = '{1'b0, 9'd0,  1'b1, 9'h0FF, 1'b1, 1'b0, 1'b0, 8'd1, 9'h1AA, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[13] = '{1'b0, 9'd0,  1'b1, 9'h0FF, 1'b1, 1'b0, 1'b0, 8'd1, 9'h1AA, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};

    reset = 1'b1;
    drive(1'b0, 9'd0, 1'b0, 9'h000, 1'b0);
    step();
    step();
    chk("rst.in_ready",  32'(bus.in_ready),    32'd0);
    chk("rst.imem_we",   32'(bus.imem_we),     32'd0);
    chk("rst.waddr",     32'(bus.imem_waddr),  32'd0);
    chk("rst.wdata",     32'(bus.imem_wdata),  32'd0);
    chk("rst.cpu_reset", 32'(bus.cpu_reset),   32'd1);
    chk("rst.cpu_start", 32'(bus.cpu_start),   32'd0);
    chk("rst.busy",      32'(bus.busy),        32'd0);
    chk("rst.run_done",  32'(bus.run_done),    32'd0);
    chk("rst.cycles",    32'(bus.cycle_count), 32'd0);
    chk("rst.timeout",   32'(bus.timeout),     32'd0);
    reset = 1'b0;

    run_rows(0, 5);

    // T3: done appears after 10 counted RUN cycles.
    for (int j = 1; j <= 10; j++) begin
      drive(1'b0, 9'd0, 1'b0, 9'h000, 1'b0);
      step();
      chk($sformatf("t3.cycles%0d", j), 32'(bus.cycle_count), 32'(j));
      chk($sformatf("t3.busy%0d", j),   32'(bus.busy),        32'd1);
    end
    drive(1'b0, 9'd0, 1'b0, 9'h000, 1'b1);
    step();
    chk("t3.run_done",  32'(bus.run_done),    32'd1);
    chk("t3.cycles",    32'(bus.cycle_count), 32'd10);
    chk("t3.timeout",   32'(bus.timeout),     32'd0);
    chk("t3.cpu_reset", 32'(bus.cpu_reset),   32'd0);
    step();
    chk("t3.cycles_held", 32'(bus.cycle_count), 32'd10);

    run_rows(6, 13);

    // T4: length 300 clamps to 256 words, last address 8'hFF.
    drive(1'b1, 9'd300, 1'b0, 9'h000, 1'b0);
    step();
    chk("t4.busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 256; i++) begin
      logic [8:0] w;
      w = 9'((i * 7 + 3) % 512);
      drive(1'b0, 9'd0, 1'b1, w, 1'b0);
      step();
      chk($sformatf("t4.we%0d", i),    32'(bus.imem_we),    32'd1);
      chk($sformatf("t4.addr%0d", i),  32'(bus.imem_waddr), 32'(i));
      chk($sformatf("t4.data%0d", i),  32'(bus.imem_wdata), 32'(w));
      chk($sformatf("t4.ready%0d", i), 32'(bus.in_ready),   (i < 255) ? 32'd1 : 32'd0);
    end
    chk("t4.cpu_start", 32'(bus.cpu_start), 32'd1);
    drive(1'b0, 9'd0, 1'b1, 9'h000, 1'b0);
    step();
    chk("t4.no_extra_write", 32'(bus.imem_we), 32'd0);
    drive(1'b0, 9'd0, 1'b0, 9'h000, 1'b1);
    step();
    chk("t4.run_done", 32'(bus.run_done), 32'd1);

    // T5: reset in the middle of a load, then a fresh load restarts at 0.
    drive(1'b1, 9'd4, 1'b0, 9'h000, 1'b0);
    step();
    drive(1'b0, 9'd0, 1'b1, 9'h011, 1'b0);
    step();
    drive(1'b0, 9'd0, 1'b1, 9'h022, 1'b0);
    step();
    chk("t5.pre_addr", 32'(bus.imem_waddr), 32'd1);
    reset = 1'b1;
    step();
    chk("t5.in_ready",  32'(bus.in_ready),    32'd0);
    chk("t5.cpu_reset", 32'(bus.cpu_reset),   32'd1);
    chk("t5.busy",      32'(bus.busy),        32'd0);
    chk("t5.imem_we",   32'(bus.imem_we),     32'd0);
    chk("t5.cycles",    32'(bus.cycle_count), 32'd0);
    chk("t5.run_done",  32'(bus.run_done),    32'd0);
    reset = 1'b0;
    drive(1'b0, 9'd0, 1'b0, 9'h000, 1'b0);
    step();
    chk("t5.idle_busy", 32'(bus.busy), 32'd0);
    drive(1'b1, 9'd2, 1'b0, 9'h000, 1'b0);
    step();
    drive(1'b0, 9'd0, 1'b1, 9'h033, 1'b0);
    step();
    chk("t5.addr0", 32'(bus.imem_waddr), 32'd0);
    chk("t5.data0", 32'(bus.imem_wdata), 32'h033);
    drive(1'b0, 9'd0, 1'b1, 9'h044, 1'b0);
    step();
    chk("t5.addr1", 32'(bus.imem_waddr), 32'd1);
    chk("t5.start", 32'(bus.cpu_start),  32'd1);
    drive(1'b0, 9'd0, 1'b0, 9'h000, 1'b0);
    step();
    chk("t6.run_cycles0", 32'(bus.cycle_count), 32'd0);

`ifdef LOADER_WATCHDOG_EN
    // T6: done never rises; watchdog ends the run at WDOG_LIMIT cycles.
    for (int k = 0; k < 100 && !bus.run_done; k++) step();
    chk("t6.run_done",  32'(bus.run_done),    32'd1);
    chk("t6.timeout",   32'(bus.timeout),     32'd1);
    chk("t6.cycles",    32'(bus.cycle_count), 32'd20);
    chk("t6.cpu_reset", 32'(bus.cpu_reset),   32'd1);
    chk("t6.busy",      32'(bus.busy),        32'd0);
`else
    // Without the watchdog the run simply keeps counting.
    for (int k = 0; k < 30; k++) step();
    chk("t6.cycles",    32'(bus.cycle_count), 32'd30);
    chk("t6.busy",      32'(bus.busy),        32'd1);
    chk("t6.run_done",  32'(bus.run_done),    32'd0);
    chk("t6.timeout",   32'(bus.timeout),     32'd0);
    chk("t6.cpu_reset", 32'(bus.cpu_reset),   32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
